// File: rtl/call_stack_pkg.sv
// Shared types and pointer helpers for the return-address stack.
// Contents:
//   stk_mode_e - overflow behaviour (saturate or circular)
//   stk_op_e   - per-cycle operation decoded from {push, pop, empty}
//   ptr_inc / ptr_dec - modulo-depth pointer steps. These compare against
//     the end values explicitly, so non-power-of-two depths wrap correctly.
package call_stack_pkg;

  typedef enum logic {
    STK_SAT,
    STK_WRAP
  } stk_mode_e;

  typedef enum logic [1:0] {
    STK_NOP,
    STK_PUSH,
    STK_POP,
    STK_REPL
  } stk_op_e;

  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

  function automatic int unsigned ptr_dec(input int unsigned ptr, input int unsigned depth);
    return (ptr == 0) ? depth - 1 : ptr - 1;
  endfunction

  // Push together with pop on an empty stack degrades to a plain push.
  function automatic stk_op_e op_decode(input logic push, input logic pop, input logic empty);
    if (push && pop && !empty) return STK_REPL;
    if (push)                  return STK_PUSH;
    if (pop)                   return STK_POP;
    return STK_NOP;
  endfunction

endpackage

// File: rtl/call_stack_ram.sv
// DEPTH x AW register file that holds the stack entries.
// Ports:
//   clk, rst (async, active-low; clears every entry to 0)
//   we, waddr, wdata - single synchronous write port
//   raddr, rdata     - asynchronous read port
module call_stack_ram #(
  parameter int unsigned AW    = 11,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [AW-1:0] wdata,
  input  logic [PW-1:0] raddr,
  output logic [AW-1:0] rdata
);

  logic [AW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/call_stack_ctrl.sv
// Hardware return-address stack that feeds PC_next on CALL/RETURN.
// Ports:
//   clk, rst         - clock; async active-low reset
//   clr              - synchronous flush of pointer, count and error flags (entries kept)
//   push, push_data  - push a return address
//   pop              - pop the top entry; push+pop on a non-empty stack replaces the top
//   err_clr          - clear the sticky ovf/unf flags (a new error in the same cycle wins)
//   top_q            - current top entry, combinational from registered state only
//   count, empty, full - occupancy
//   ovf, unf         - sticky overflow / underflow flags
// WRAP=0 saturates (drops a push when full, ignores a pop when empty).
// WRAP=1 behaves as a circular stack: the pointer always moves.
module call_stack_ctrl import call_stack_pkg::*; #(
  parameter int unsigned AW    = 11,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WRAP  = 0,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  input  logic          err_clr,
  output logic [AW-1:0] top_q,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          ovf,
  output logic          unf
);

  localparam int unsigned PW      = $clog2(DEPTH);
  localparam stk_mode_e   Mode    = (WRAP != 0) ? STK_WRAP : STK_SAT;
  localparam logic [CW-1:0] CntFull = CW'(DEPTH);

  logic [PW-1:0] sp_q, sp_d, sp_inc, sp_dec;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          we;
  logic [PW-1:0] waddr;
  logic [AW-1:0] rdata;
  stk_op_e       op;

  assign sp_inc = PW'(ptr_inc(32'(sp_q), DEPTH));
  assign sp_dec = PW'(ptr_dec(32'(sp_q), DEPTH));

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CntFull);
  assign count = cnt_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
  assign op    = op_decode(push, pop, empty);

  // The top entry sits just below sp; a saturating stack reports 0 when empty,
  // a circular one keeps exposing whatever the pointer lands on.
  assign top_q = (empty && (Mode == STK_SAT)) ? '0 : rdata;

  call_stack_ram #(
    .AW   (AW),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .waddr(waddr),
    .wdata(push_data),
    .raddr(sp_dec),
    .rdata(rdata)
  );

  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    we    = 1'b0;
    waddr = sp_q;
    // Clear first so that an error raised below in the same cycle sticks.
    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (clr) begin
      sp_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      unique case (op)
        STK_PUSH: begin
          if (!full) begin
            we    = 1'b1;
            sp_d  = sp_inc;
            cnt_d = cnt_q + CW'(1);
          end else begin
            ovf_d = 1'b1;
            if (Mode == STK_WRAP) begin
              we   = 1'b1;
              sp_d = sp_inc;
            end
          end
        end
        STK_POP: begin
          if (!empty) begin
            sp_d  = sp_dec;
            cnt_d = cnt_q - CW'(1);
          end else begin
            unf_d = 1'b1;
            if (Mode == STK_WRAP) sp_d = sp_dec;
          end
        end
        STK_REPL: begin
          we    = 1'b1;
          waddr = sp_dec;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Directed bench for call_stack_ctrl. Four instances cover the configurations:
//   0: DEPTH=8 WRAP=0, 1: DEPTH=4 WRAP=0, 2: DEPTH=4 WRAP=1, 3: DEPTH=5 WRAP=1.
// Expected states are queued when stimulus is driven and compared when sampled.
module tb_call_stack_ctrl;

  localparam int unsigned AW = 11;
  localparam int NDUT = 4;

  typedef struct packed {
    logic [AW-1:0] top;
    logic [3:0]    cnt;
    logic          empty;
    logic          full;
    logic          ovf;
    logic          unf;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic          clr_v  [NDUT];
  logic          push_v [NDUT];
  logic          pop_v  [NDUT];
  logic          errc_v [NDUT];
  logic [AW-1:0] data_v [NDUT];
  logic [AW-1:0] top_v  [NDUT];
  logic          empty_v[NDUT];
  logic          full_v [NDUT];
  logic          ovf_v  [NDUT];
  logic          unf_v  [NDUT];
  logic [3:0]    cnt0;
  logic [2:0]    cnt1, cnt2, cnt3;
  obs_t          obs    [NDUT];

  obs_t  exp_q[$];
  int    dut_q[$];
  string tag_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  logic [AW-1:0] t6_pop_tops [7];

  always #5 clk = ~clk;

  call_stack_ctrl #(.AW(AW), .DEPTH(8), .WRAP(0)) u_d8 (
    .clk(clk), .rst(rst), .clr(clr_v[0]), .push(push_v[0]), .pop(pop_v[0]),
    .push_data(data_v[0]), .err_clr(errc_v[0]), .top_q(top_v[0]), .count(cnt0),
    .empty(empty_v[0]), .full(full_v[0]), .ovf(ovf_v[0]), .unf(unf_v[0])
  );
  call_stack_ctrl #(.AW(AW), .DEPTH(4), .WRAP(0)) u_s4 (
    .clk(clk), .rst(rst), .clr(clr_v[1]), .push(push_v[1]), .pop(pop_v[1]),
    .push_data(data_v[1]), .err_clr(errc_v[1]), .top_q(top_v[1]), .count(cnt1),
    .empty(empty_v[1]), .full(full_v[1]), .ovf(ovf_v[1]), .unf(unf_v[1])
  );
  call_stack_ctrl #(.AW(AW), .DEPTH(4), .WRAP(1)) u_w4 (
    .clk(clk), .rst(rst), .clr(clr_v[2]), .push(push_v[2]), .pop(pop_v[2]),
    .push_data(data_v[2]), .err_clr(errc_v[2]), .top_q(top_v[2]), .count(cnt2),
    .empty(empty_v[2]), .full(full_v[2]), .ovf(ovf_v[2]), .unf(unf_v[2])
  );
  call_stack_ctrl #(.AW(AW), .DEPTH(5), .WRAP(1)) u_w5 (
    .clk(clk), .rst(rst), .clr(clr_v[3]), .push(push_v[3]), .pop(pop_v[3]),
    .push_data(data_v[3]), .err_clr(errc_v[3]), .top_q(top_v[3]), .count(cnt3),
    .empty(empty_v[3]), .full(full_v[3]), .ovf(ovf_v[3]), .unf(unf_v[3])
  );

  always_comb begin
    for (int i = 0; i < NDUT; i++) begin
      obs[i].top   = top_v[i];
      obs[i].cnt   = '0;
      obs[i].empty = empty_v[i];
      obs[i].full  = full_v[i];
      obs[i].ovf   = ovf_v[i];
      obs[i].unf   = unf_v[i];
    end
    obs[0].cnt = cnt0;
    obs[1].cnt = {1'b0, cnt1};
    obs[2].cnt = {1'b0, cnt2};
    obs[3].cnt = {1'b0, cnt3};
  end

  task automatic idle();
    for (int i = 0; i < NDUT; i++) begin
      clr_v[i]  = 1'b0;
      push_v[i] = 1'b0;
      pop_v[i]  = 1'b0;
      errc_v[i] = 1'b0;
      data_v[i] = '0;
    end
  endtask

  task automatic drive(input int d, input logic pu, input logic po, input logic [AW-1:0] dat,
                       input logic cl, input logic ec);
    clr_v[d]  = cl;
    push_v[d] = pu;
    pop_v[d]  = po;
    errc_v[d] = ec;
    data_v[d] = dat;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic cyc(input int d, input logic pu, input logic po, input logic [AW-1:0] dat,
                     input logic cl, input logic ec);
    drive(d, pu, po, dat, cl, ec);
    tick();
  endtask

  task automatic expect_st(input int d, input string tag, input logic [AW-1:0] top, input int cnt,
                           input logic e, input logic f, input logic o, input logic u);
    obs_t x;
    x.top   = top;
    x.cnt   = 4'(cnt);
    x.empty = e;
    x.full  = f;
    x.ovf   = o;
    x.unf   = u;
    exp_q.push_back(x);
    dut_q.push_back(d);
    tag_q.push_back(tag);
  endtask

  task automatic check_next();
    obs_t  e;
    obs_t  a;
    int    d;
    string t;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_underrun: no expected entry queued");
      return;
    end
    e = exp_q.pop_front();
    d = dut_q.pop_front();
    t = tag_q.pop_front();
    a = obs[d];
    assert (a === e) else begin
      miscompares++;
      $error("FAIL %s dut%0d: got top=%h cnt=%0d empty=%b full=%b ovf=%b unf=%b, expected top=%h cnt=%0d empty=%b full=%b ovf=%b unf=%b",
             t, d, a.top, a.cnt, a.empty, a.full, a.ovf, a.unf,
             e.top, e.cnt, e.empty, e.full, e.ovf, e.unf);
    end
  endtask

  initial begin
    t6_pop_tops = '{11'h0B6, 11'h0B5, 11'h0B4, 11'h0B3, 11'h0B2, 11'h0B6, 11'h0B5};
    idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    for (int d = 0; d < NDUT; d++) begin
      expect_st(d, "reset", '0, 0, 1, 0, 0, 0);
      check_next();
    end

    // Basic push/pop, zero-latency top on the pop cycle.
    expect_st(0, "t1_push3", 11'h030, 3, 0, 0, 0, 0);
    cyc(0, 1, 0, 11'h010, 0, 0);
    cyc(0, 1, 0, 11'h020, 0, 0);
    cyc(0, 1, 0, 11'h030, 0, 0);
    check_next();
    drive(0, 0, 1, '0, 0, 0);
    expect_st(0, "t1_pop_during", 11'h030, 3, 0, 0, 0, 0);
    check_next();
    expect_st(0, "t1_pop_after", 11'h020, 2, 0, 0, 0, 0);
    tick();
    check_next();

    // Saturating, DEPTH=4.
    expect_st(1, "t2_fill", 11'h004, 4, 0, 1, 1, 0);
    for (int i = 1; i <= 5; i++) cyc(1, 1, 0, 11'(i), 0, 0);
    check_next();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1, '0, 0, 0);
      expect_st(1, "t2_pop", 11'(4 - i), 4 - i, 0, (i == 0), 1, 0);
      check_next();
      tick();
    end
    expect_st(1, "t2_drained", '0, 0, 1, 0, 1, 0);
    check_next();
    expect_st(1, "t2_underflow", '0, 0, 1, 0, 1, 1);
    cyc(1, 0, 1, '0, 0, 0);
    check_next();

    // Circular, DEPTH=4.
    expect_st(2, "t3_fill", 11'h005, 4, 0, 1, 1, 0);
    for (int i = 1; i <= 5; i++) cyc(2, 1, 0, 11'(i), 0, 0);
    check_next();
    for (int i = 0; i < 4; i++) begin
      drive(2, 0, 1, '0, 0, 0);
      expect_st(2, "t3_pop", 11'(5 - i), 4 - i, 0, (i == 0), 1, 0);
      check_next();
      tick();
    end
    drive(2, 0, 1, '0, 0, 0);
    expect_st(2, "t3_pop_wrap", 11'h005, 0, 1, 0, 1, 0);
    check_next();
    tick();
    expect_st(2, "t3_underflow", 11'h004, 0, 1, 0, 1, 1);
    check_next();

    // clr beats a simultaneous push, then replace-top and push+pop on empty.
    expect_st(0, "t4_clr", '0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 11'h7AA, 1, 0);
    check_next();
    cyc(0, 1, 0, 11'h100, 0, 0);
    cyc(0, 1, 0, 11'h200, 0, 0);
    expect_st(0, "t4_replace", 11'h3FF, 2, 0, 0, 0, 0);
    cyc(0, 1, 1, 11'h3FF, 0, 0);
    check_next();
    expect_st(0, "t4_pop_after_replace", 11'h100, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, '0, 0, 0);
    check_next();
    expect_st(0, "t4_pop_to_empty", '0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, '0, 0, 0);
    check_next();
    expect_st(0, "t4_pushpop_empty", 11'h055, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 11'h055, 0, 0);
    check_next();

    // Sticky flags and err_clr priority.
    cyc(0, 0, 1, '0, 0, 0);
    expect_st(0, "t5_underflow", '0, 0, 1, 0, 0, 1);
    cyc(0, 0, 1, '0, 0, 0);
    check_next();
    expect_st(0, "t5_fill", 11'h0A7, 8, 0, 1, 0, 1);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 11'h0A0 + 11'(i), 0, 0);
    check_next();
    expect_st(0, "t5_overflow", 11'h0A7, 8, 0, 1, 1, 1);
    cyc(0, 1, 0, 11'h0FF, 0, 0);
    check_next();
    expect_st(0, "t5_errclr_vs_set", 11'h0A7, 8, 0, 1, 1, 0);
    cyc(0, 1, 0, 11'h0EE, 0, 1);
    check_next();
    expect_st(0, "t5_errclr", 11'h0A7, 8, 0, 1, 0, 0);
    cyc(0, 0, 0, '0, 0, 1);
    check_next();
    expect_st(0, "t5_replace_full", 11'h123, 8, 0, 1, 0, 0);
    cyc(0, 1, 1, 11'h123, 0, 0);
    check_next();

    // Non-power-of-two circular stack, DEPTH=5.
    for (int i = 0; i < 7; i++) begin
      expect_st(3, "t6_push", 11'h0B0 + 11'(i), (i < 5) ? i + 1 : 5, 0, (i >= 4), (i >= 5), 0);
      cyc(3, 1, 0, 11'h0B0 + 11'(i), 0, 0);
      check_next();
    end
    for (int k = 0; k < 7; k++) begin
      drive(3, 0, 1, '0, 0, 0);
      expect_st(3, "t6_pop", t6_pop_tops[k], (k < 5) ? 5 - k : 0, (k >= 5), (k == 0), 1, (k == 6));
      check_next();
      tick();
    end
    expect_st(3, "t6_after_pops", 11'h0B4, 0, 1, 0, 1, 1);
    check_next();

    // Asynchronous reset in the middle of a push cycle.
    drive(3, 1, 0, 11'h7FF, 0, 0);
    #2 rst = 1'b0;
    #1;
    expect_st(3, "t6_async_reset", '0, 0, 1, 0, 0, 0);
    check_next();
    @(posedge clk);
    #1;
    expect_st(3, "t6_reset_held", '0, 0, 1, 0, 0, 0);
    check_next();
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    expect_st(3, "t6_after_reset", '0, 0, 1, 0, 0, 0);
    check_next();
    expect_st(0, "t6_reset_other", '0, 0, 1, 0, 0, 0);
    check_next();

    vectors++;
    assert (exp_q.size() == 0) else begin
      miscompares++;
      $error("FAIL scoreboard_leftover: got %0d entries, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
